// File: rtl/if_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : if_pkg
//  Description : Shared types and constants for the IF-stage fetch sequencer:
//                fetch state encoding, reset PC, instruction size and the
//                {pc, inst} fetch-entry record.
//  Revision    : 1.0 - initial release
// ============================================================================
package if_pkg;

  localparam int unsigned          IF_XLEN          = 32;
  localparam logic [IF_XLEN-1:0]   RESET_PC_DEFAULT = 32'hBFC0_0000;
  localparam logic [IF_XLEN-1:0]   INST_BYTES       = 32'd4;

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [IF_XLEN-1:0] pc;
    logic [IF_XLEN-1:0] inst;
  } fetch_entry_t;

  // Fetch addresses are always word aligned; low two bits are forced to zero.
  function automatic logic [IF_XLEN-1:0] word_align(input logic [IF_XLEN-1:0] a);
    return {a[IF_XLEN-1:2], 2'b00};
  endfunction

endpackage
`default_nettype wire

// File: rtl/if_out_buf.sv
`default_nettype none
// ============================================================================
//  Module      : if_out_buf
//  Description : Single-entry registered {pc, inst} buffer presented to
//                decode. Load wins over flush, flush wins over consume.
//  Revision    : 1.0 - initial release
// ============================================================================
module if_out_buf
  import if_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic         flush_i,
  input  logic         stall_i,
  input  fetch_entry_t entry_i,
  output logic         valid_o,
  output fetch_entry_t entry_o
);

  logic         valid_q;
  fetch_entry_t entry_q;

  // Entry register: contents only change on load, valid drops on flush/consume.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      entry_q <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      entry_q <= entry_i;
    end else if (flush_i || (valid_q && !stall_i)) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign entry_o = entry_q;

endmodule
`default_nettype wire

// File: rtl/if_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : if_fetch_ctrl
//  Description : IF-stage fetch sequencer. Owns the fetch PC, issues I-cache
//                requests (req/ready/valid), applies redirects with optional
//                branch-cache target substitution, and feeds decode through a
//                single registered output entry.
//  Revision    : 1.0 - initial release
// ============================================================================
module if_fetch_ctrl
  import if_pkg::*;
#(
  parameter int unsigned      XLEN     = 32,
  parameter logic [XLEN-1:0]  RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            io_redirect_valid,
  input  logic [XLEN-1:0] io_redirect_pc,
  input  logic            io_bc_hit,
  input  logic [XLEN-1:0] io_bc_pc,
  input  logic [XLEN-1:0] io_bc_inst,
  output logic            io_cache_req,
  output logic [XLEN-1:0] io_cache_addr,
  input  logic            io_cache_ready,
  input  logic            io_cache_valid,
  input  logic [XLEN-1:0] io_cache_dout,
  input  logic            io_stall,
  output logic            io_out_valid,
  output logic [XLEN-1:0] io_out_pc,
  output logic [XLEN-1:0] io_out_inst
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic            kill_q, kill_d;
  fetch_entry_t    hold_q, hold_d;

  logic            buf_load, buf_flush, buf_valid;
  fetch_entry_t    buf_entry, buf_out;
  logic            can_load;

  // Decode can take a new entry if the buffer is empty or drains this cycle.
  assign can_load      = !buf_valid || !io_stall;
  // A redirect suppresses the request, so a redirect never races a handshake.
  assign io_cache_req  = reset && (state_q == ST_REQ) && can_load && !io_redirect_valid;
  assign io_cache_addr = word_align(pc_q);

  // Next-state logic: redirect first, then the REQ/WAIT/HOLD sequencing.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    req_pc_d  = req_pc_q;
    kill_d    = kill_q;
    hold_d    = hold_q;
    buf_load  = 1'b0;
    buf_flush = 1'b0;
    buf_entry = hold_q;
    if (io_redirect_valid) begin
      buf_flush = 1'b1;
      // An outstanding request must be discarded when it returns, unless it
      // returns in this very cycle and is dropped right here.
      kill_d    = (state_q == ST_WAIT) && !io_cache_valid;
      state_d   = kill_d ? ST_WAIT : ST_REQ;
      if (io_bc_hit) begin
        buf_load       = 1'b1;
        buf_entry.pc   = io_bc_pc;
        buf_entry.inst = io_bc_inst;
        pc_d           = word_align(io_bc_pc + INST_BYTES);
      end else begin
        pc_d = word_align(io_redirect_pc);
      end
    end else begin
      case (state_q)
        ST_REQ: begin
          if (io_cache_req && io_cache_ready) begin
            req_pc_d = pc_q;
            state_d  = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (io_cache_valid) begin
            if (kill_q) begin
              kill_d  = 1'b0;
              state_d = ST_REQ;
            end else if (can_load) begin
              buf_load       = 1'b1;
              buf_entry.pc   = req_pc_q;
              buf_entry.inst = io_cache_dout;
              pc_d           = req_pc_q + INST_BYTES;
              state_d        = ST_REQ;
            end else begin
              hold_d.pc   = req_pc_q;
              hold_d.inst = io_cache_dout;
              pc_d        = req_pc_q + INST_BYTES;
              state_d     = ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (can_load) begin
            buf_load = 1'b1;
            state_d  = ST_REQ;
          end
        end
        default: state_d = ST_REQ;
      endcase
    end
  end

  // Sequencer state registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_REQ;
      pc_q     <= RESET_PC;
      req_pc_q <= '0;
      kill_q   <= 1'b0;
      hold_q   <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
      kill_q   <= kill_d;
      hold_q   <= hold_d;
    end
  end

  if_out_buf u_out_buf (
    .clk_i   (clock),
    .rst_ni  (reset),
    .load_i  (buf_load),
    .flush_i (buf_flush),
    .stall_i (io_stall),
    .entry_i (buf_entry),
    .valid_o (buf_valid),
    .entry_o (buf_out)
  );

  assign io_out_valid = buf_valid;
  assign io_out_pc    = buf_out.pc;
  assign io_out_inst  = buf_out.inst;

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_if_fetch_ctrl
//  Description : Self-checking bench for if_fetch_ctrl: directed scenarios
//                followed by randomized traffic against a transaction-level
//                reference model (outstanding request / stale flag / pending
//                entry) and a simple I-cache responder.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_if_fetch_ctrl;

  localparam logic [31:0] RST_PC = 32'hBFC0_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        io_redirect_valid = 1'b0;
  logic [31:0] io_redirect_pc = '0;
  logic        io_bc_hit = 1'b0;
  logic [31:0] io_bc_pc = '0;
  logic [31:0] io_bc_inst = '0;
  logic        io_cache_req;
  logic [31:0] io_cache_addr;
  logic        io_cache_ready = 1'b0;
  logic        io_cache_valid = 1'b0;
  logic [31:0] io_cache_dout = '0;
  logic        io_stall = 1'b0;
  logic        io_out_valid;
  logic [31:0] io_out_pc;
  logic [31:0] io_out_inst;

  always #5 clock = ~clock;

  if_fetch_ctrl #(.XLEN(32), .RESET_PC(RST_PC)) dut (
    .clock             (clock),
    .reset             (reset),
    .io_redirect_valid (io_redirect_valid),
    .io_redirect_pc    (io_redirect_pc),
    .io_bc_hit         (io_bc_hit),
    .io_bc_pc          (io_bc_pc),
    .io_bc_inst        (io_bc_inst),
    .io_cache_req      (io_cache_req),
    .io_cache_addr     (io_cache_addr),
    .io_cache_ready    (io_cache_ready),
    .io_cache_valid    (io_cache_valid),
    .io_cache_dout     (io_cache_dout),
    .io_stall          (io_stall),
    .io_out_valid      (io_out_valid),
    .io_out_pc         (io_out_pc),
    .io_out_inst       (io_out_inst)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: decode-facing entry, fetch PC, one outstanding request
  // (possibly stale), and one pending entry waiting for decode.
  bit          m_ov;
  logic [31:0] m_opc, m_oinst, m_pc, m_rpc, m_hpc, m_hinst;
  bit          m_out, m_stale, m_hv;

  // I-cache responder.
  bit          resp_pend = 1'b0;
  int          resp_cnt = 0;
  int          resp_lat = 1;
  logic [31:0] resp_data = '0;
  logic [31:0] dout_src = '0;
  bit          inject_valid = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ov = 0; m_opc = '0; m_oinst = '0; m_pc = RST_PC;
    m_out = 0; m_stale = 0; m_rpc = '0; m_hv = 0; m_hpc = '0; m_hinst = '0;
  endtask

  task automatic model_step(input bit can, input bit req);
    if (io_redirect_valid) begin
      if (io_bc_hit) begin
        m_ov = 1; m_opc = io_bc_pc; m_oinst = io_bc_inst;
        m_pc = (io_bc_pc + 32'd4) & 32'hFFFF_FFFC;
      end else begin
        m_ov = 0;
        m_pc = io_redirect_pc & 32'hFFFF_FFFC;
      end
      m_hv = 0;
      if (m_out) begin
        if (io_cache_valid) begin m_out = 0; m_stale = 0; end
        else m_stale = 1;
      end
    end else begin
      if (m_ov && !io_stall) m_ov = 0;
      if (m_out && io_cache_valid) begin
        m_out = 0;
        if (m_stale) m_stale = 0;
        else begin
          m_pc = m_rpc + 32'd4;
          if (can) begin m_ov = 1; m_opc = m_rpc; m_oinst = io_cache_dout; end
          else begin m_hv = 1; m_hpc = m_rpc; m_hinst = io_cache_dout; end
        end
      end else if (m_hv) begin
        if (can) begin m_ov = 1; m_opc = m_hpc; m_oinst = m_hinst; m_hv = 0; end
      end else if (req && io_cache_ready) begin
        m_out = 1;
        m_rpc = m_pc & 32'hFFFF_FFFC;
      end
    end
  endtask

  // One clock: drive responder, check at the falling edge, advance model.
  task automatic tick();
    bit can, exp_req;
    if (inject_valid) begin
      io_cache_valid = 1; io_cache_dout = 32'hDEAD_BEEF; inject_valid = 0;
    end else if (resp_pend && resp_cnt == 0) begin
      io_cache_valid = 1; io_cache_dout = resp_data; resp_pend = 0;
    end else begin
      io_cache_valid = 0; io_cache_dout = $urandom;
      if (resp_pend) resp_cnt--;
    end
    @(negedge clock);
    if (!reset) model_reset();
    can     = !m_ov || !io_stall;
    exp_req = reset && !m_out && !m_hv && can && !io_redirect_valid;
    chk("out_valid",  {31'b0, io_out_valid}, {31'b0, m_ov});
    chk("out_pc",     io_out_pc,   m_opc);
    chk("out_inst",   io_out_inst, m_oinst);
    chk("cache_req",  {31'b0, io_cache_req}, {31'b0, exp_req});
    chk("cache_addr", io_cache_addr, m_pc & 32'hFFFF_FFFC);
    if (reset) begin
      if (exp_req && io_cache_ready) begin
        resp_pend = 1; resp_cnt = resp_lat - 1; resp_data = dout_src;
      end
      model_step(can, exp_req);
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    model_reset();
    // Reset held for a few cycles.
    tick(); tick();
    chk("rst_valid", {31'b0, io_out_valid}, 32'd0);
    chk("rst_req",   {31'b0, io_cache_req}, 32'd0);

    // 1: first fetch from the reset PC.
    reset = 1; io_cache_ready = 1; resp_lat = 1; dout_src = 32'h2408_0001;
    chk("t1_addr0", io_cache_addr, 32'hBFC0_0000);
    tick(); tick();
    chk("t1_valid", {31'b0, io_out_valid}, 32'd1);
    chk("t1_pc",    io_out_pc,     32'hBFC0_0000);
    chk("t1_inst",  io_out_inst,   32'h2408_0001);
    chk("t1_addr1", io_cache_addr, 32'hBFC0_0004);

    // 2: decode stall holds the entry and blocks requests; release advances.
    io_stall = 1; dout_src = 32'h1111_2222;
    for (int i = 0; i < 5; i++) tick();
    chk("t2_hold_pc", io_out_pc, 32'hBFC0_0000);
    io_stall = 0;
    tick(); tick();
    chk("t2_next_pc",   io_out_pc,     32'hBFC0_0004);
    chk("t2_next_inst", io_out_inst,   32'h1111_2222);
    chk("t2_addr",      io_cache_addr, 32'hBFC0_0008);

    // 3: redirect while waiting; the stale response must be dropped.
    resp_lat = 2; dout_src = 32'hBAD0_0BAD;
    tick();
    io_redirect_valid = 1; io_redirect_pc = 32'h8000_1003;
    tick();
    io_redirect_valid = 0;
    tick();
    chk("t3_valid", {31'b0, io_out_valid}, 32'd0);
    chk("t3_addr",  io_cache_addr, 32'h8000_1000);

    // 4: redirect with a branch-cache hit.
    io_redirect_valid = 1; io_redirect_pc = 32'h8000_2000;
    io_bc_hit = 1; io_bc_pc = 32'h8000_2000; io_bc_inst = 32'h1000_FFFF;
    tick();
    io_redirect_valid = 0; io_bc_hit = 0;
    chk("t4_valid", {31'b0, io_out_valid}, 32'd1);
    chk("t4_pc",    io_out_pc,     32'h8000_2000);
    chk("t4_inst",  io_out_inst,   32'h1000_FFFF);
    chk("t4_addr",  io_cache_addr, 32'h8000_2004);

    // 5: PC wrap at the top of the address space.
    io_redirect_valid = 1; io_redirect_pc = 32'hFFFF_FFFC;
    tick();
    io_redirect_valid = 0; resp_lat = 1;
    tick(); tick();
    chk("t5_addr", io_cache_addr, 32'h0000_0000);

    // 6: reset mid-WAIT, then a stray response after release.
    resp_lat = 3;
    tick();
    reset = 0;
    #1;
    chk("t6_valid", {31'b0, io_out_valid}, 32'd0);
    chk("t6_pc",    io_out_pc,   32'd0);
    chk("t6_inst",  io_out_inst, 32'd0);
    chk("t6_req",   {31'b0, io_cache_req}, 32'd0);
    resp_pend = 0;
    tick(); tick();
    reset = 1; io_cache_ready = 0; inject_valid = 1;
    tick();
    chk("t6_stray", {31'b0, io_out_valid}, 32'd0);
    chk("t6_addr",  io_cache_addr, 32'hBFC0_0000);
    io_cache_ready = 1; resp_lat = 1; dout_src = 32'h0000_0042;
    tick(); tick();
    chk("t6_pc2",   io_out_pc,   32'hBFC0_0000);
    chk("t6_inst2", io_out_inst, 32'h0000_0042);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 4000; i++) begin
      reset             = ($urandom_range(0, 499) != 0);
      io_redirect_valid = ($urandom_range(0, 9) == 0);
      io_redirect_pc    = $urandom;
      io_bc_hit         = $urandom_range(0, 1) == 1;
      io_bc_pc          = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC : $urandom;
      io_bc_inst        = $urandom;
      io_stall          = ($urandom_range(0, 9) < 3);
      io_cache_ready    = ($urandom_range(0, 9) < 7);
      resp_lat          = $urandom_range(1, 3);
      dout_src          = $urandom;
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
